// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-file / write-back settings and the write-port select encoding.
package wb_write_arbiter_pkg;

    localparam int unsigned WORD_WIDTH       = 32;
    localparam int unsigned REG_FILE_DEPTH   = 4;
    localparam int unsigned REG_FILE_SIZE    = 16;
    localparam int unsigned LQ_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        SelNone,
        SelAlu,
        SelLoad
    } wb_sel_e;

endpackage

// File: rtl/wb_load_queue.sv
// Load-return FIFO with a per-entry kill bit, kill-by-destination compare and pending mask.
module wb_load_queue
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W   = WORD_WIDTH,
    parameter int unsigned ADDR_W   = REG_FILE_DEPTH,
    parameter int unsigned NREGS    = REG_FILE_SIZE,
    parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [ADDR_W-1:0]           push_dest,
    input  logic [WORD_W-1:0]           push_data,
    input  logic                        push_kill,
    input  logic                        pop,
    input  logic                        kill_en,
    input  logic [ADDR_W-1:0]           kill_dest,
    output logic [ADDR_W-1:0]           head_dest,
    output logic [WORD_W-1:0]           head_data,
    output logic                        head_kill,
    output logic [$clog2(LQ_DEPTH):0]   count,
    output logic                        full,
    output logic [NREGS-1:0]            pend_mask
);

    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FullCount = CNT_W'(LQ_DEPTH);

    logic [ADDR_W-1:0]   dest_q [LQ_DEPTH];
    logic [WORD_W-1:0]   data_q [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] valid_q, valid_d;
    logic [LQ_DEPTH-1:0] kill_q, kill_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                push_ok, pop_ok;

    assign full    = (count_q == FullCount);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);

    assign head_dest = dest_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign head_kill = kill_q[rd_ptr_q];

    // Kill applies only to entries already held; a same-cycle push carries its own kill bit.
    always_comb begin
        valid_d = valid_q;
        kill_d  = kill_q;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (kill_en && valid_q[i] && (dest_q[i] == kill_dest)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            kill_d[wr_ptr_q]  = push_kill;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i]) begin
                pend_mask[dest_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            kill_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            kill_q  <= kill_d;
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                dest_q[wr_ptr_q] <= push_dest;
                data_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: ALU results take the port, queued loads fill idle cycles.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W   = WORD_WIDTH,
    parameter int unsigned ADDR_W   = REG_FILE_DEPTH,
    parameter int unsigned NREGS    = REG_FILE_SIZE,
    parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [ADDR_W-1:0]           alu_dest,
    input  logic [WORD_W-1:0]           alu_result,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [ADDR_W-1:0]           ld_dest,
    input  logic [WORD_W-1:0]           ld_data,
    output logic                        WB_en,
    output logic [ADDR_W-1:0]           WB_dest,
    output logic [WORD_W-1:0]           WB_result,
    output logic [NREGS-1:0]            pend_mask,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    logic [ADDR_W-1:0] head_dest;
    logic [WORD_W-1:0] head_data;
    logic              head_kill;
    logic              lq_full;
    logic              lq_nonempty;
    logic              push, push_kill, pop;
    wb_sel_e           sel;

    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [WORD_W-1:0] wb_result_q, wb_result_d;

    assign ld_ready    = !rst && !lq_full;
    assign push        = ld_valid && ld_ready;
    // Loads accepted alongside an ALU write are older, so a matching dest is already dead.
    assign push_kill   = alu_valid && (ld_dest == alu_dest);
    assign lq_nonempty = (lq_count != '0);

    always_comb begin
        sel = SelNone;
        if (alu_valid) begin
            sel = SelAlu;
        end else if (lq_nonempty && !head_kill) begin
            sel = SelLoad;
        end
    end

    // A killed head leaves without using the port, even under an ALU write.
    assign pop = (sel == SelLoad) || (lq_nonempty && head_kill);

    wb_load_queue #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .NREGS    (NREGS),
        .LQ_DEPTH (LQ_DEPTH)
    ) u_load_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_dest (ld_dest),
        .push_data (ld_data),
        .push_kill (push_kill),
        .pop       (pop),
        .kill_en   (alu_valid),
        .kill_dest (alu_dest),
        .head_dest (head_dest),
        .head_data (head_data),
        .head_kill (head_kill),
        .count     (lq_count),
        .full      (lq_full),
        .pend_mask (pend_mask)
    );

    always_comb begin
        wb_en_d     = 1'b0;
        wb_dest_d   = wb_dest_q;
        wb_result_d = wb_result_q;
        unique case (sel)
            SelAlu: begin
                wb_en_d     = 1'b1;
                wb_dest_d   = alu_dest;
                wb_result_d = alu_result;
            end
            SelLoad: begin
                wb_en_d     = 1'b1;
                wb_dest_d   = head_dest;
                wb_result_d = head_data;
            end
            default: begin
                wb_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q     <= 1'b0;
            wb_dest_q   <= '0;
            wb_result_q <= '0;
        end else begin
            wb_en_q     <= wb_en_d;
            wb_dest_q   <= wb_dest_d;
            wb_result_q <= wb_result_d;
        end
    end

    assign WB_en     = wb_en_q;
    assign WB_dest   = wb_dest_q;
    assign WB_result = wb_result_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected port writes go to a scoreboard queue.
module tb_wb_write_arbiter;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NREGS    = 16;
    localparam int unsigned LQ_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_dest = '0;
    logic [WORD_W-1:0] alu_result = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_dest = '0;
    logic [WORD_W-1:0] ld_data = '0;
    logic              WB_en;
    logic [ADDR_W-1:0] WB_dest;
    logic [WORD_W-1:0] WB_result;
    logic [NREGS-1:0]  pend_mask;
    logic [2:0]        lq_count;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;

    wb_write_arbiter #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .NREGS    (NREGS),
        .LQ_DEPTH (LQ_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_dest   (alu_dest),
        .alu_result (alu_result),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_dest    (ld_dest),
        .ld_data    (ld_data),
        .WB_en      (WB_en),
        .WB_dest    (WB_dest),
        .WB_result  (WB_result),
        .pend_mask  (pend_mask),
        .lq_count   (lq_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Every write seen on the port must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && WB_en) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", {28'd0, WB_dest, WB_result}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wb_dest", 64'(WB_dest), 64'(mon_e.dest));
                check_eq("wb_data", 64'(WB_result), 64'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] d, input logic [WORD_W-1:0] r);
        exp_q.push_back({d, r});
    endtask

    task automatic drive_alu(input logic v, input logic [ADDR_W-1:0] d,
                             input logic [WORD_W-1:0] r);
        alu_valid  = v;
        alu_dest   = d;
        alu_result = r;
        if (v) expect_wr(d, r);
    endtask

    task automatic drive_ld(input logic v, input logic [ADDR_W-1:0] d,
                            input logic [WORD_W-1:0] r);
        ld_valid = v;
        ld_dest  = d;
        ld_data  = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then reset again with three loads queued
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_ready_low", 64'(ld_ready), 64'd0);
        check_eq("rst_wb_en", 64'(WB_en), 64'd0);
        rst = 1'b0;
        tick();
        check_eq("rel_ready", 64'(ld_ready), 64'd1);
        check_eq("rel_count", 64'(lq_count), 64'd0);
        check_eq("rel_pend", 64'(pend_mask), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drive_alu(1'b1, 4'(12 + k), 32'hC0 + k);
            drive_ld(1'b1, 4'(1 + k), 32'hD0 + k);
            tick();
        end
        drive_alu(1'b0, '0, '0);
        drive_ld(1'b0, '0, '0);
        @(negedge clk);
        #1;
        check_eq("t1_count3", 64'(lq_count), 64'd3);
        check_eq("t1_pend3", 64'(pend_mask), 64'h000E);
        rst = 1'b1;
        #1;
        check_eq("t1_rst_wb_en", 64'(WB_en), 64'd0);
        check_eq("t1_rst_count", 64'(lq_count), 64'd0);
        check_eq("t1_rst_pend", 64'(pend_mask), 64'd0);
        check_eq("t1_rst_ready", 64'(ld_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("t1_ready_after", 64'(ld_ready), 64'd1);
        repeat (4) tick();
        check_eq("t1_no_stale", 64'(exp_q.size()), 64'd0);

        // Single ALU write latency
        drive_alu(1'b1, 4'd3, 32'h1234);
        tick();
        drive_alu(1'b0, '0, '0);
        check_eq("t2_en", 64'(WB_en), 64'd1);
        check_eq("t2_dest", 64'(WB_dest), 64'd3);
        check_eq("t2_data", 64'(WB_result), 64'h1234);
        tick();
        check_eq("t2_en_off", 64'(WB_en), 64'd0);

        // Load waits behind four ALU writes
        drive_ld(1'b1, 4'd5, 32'hAAAA);
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, 4'(1 + i), 32'h100 + i);
            tick();
            drive_ld(1'b0, '0, '0);
            check_eq("t3_pend5", 64'(pend_mask[5]), 64'd1);
        end
        drive_alu(1'b0, '0, '0);
        expect_wr(4'd5, 32'hAAAA);
        tick();
        check_eq("t3_ld_en", 64'(WB_en), 64'd1);
        check_eq("t3_ld_dest", 64'(WB_dest), 64'd5);
        check_eq("t3_pend_clear", 64'(pend_mask[5]), 64'd0);

        // Fill to full under ALU pressure; fifth load held until space frees
        for (int k = 0; k < 4; k++) begin
            drive_alu(1'b1, 4'(1 + k), 32'h500 + k);
            drive_ld(1'b1, 4'(8 + k), 32'h4000 + k);
            tick();
        end
        check_eq("t4_full_count", 64'(lq_count), 64'd4);
        check_eq("t4_full_ready", 64'(ld_ready), 64'd0);
        drive_ld(1'b1, 4'd12, 32'h4004);
        for (int j = 0; j < 2; j++) begin
            drive_alu(1'b1, 4'(5 + j), 32'h600 + j);
            tick();
            check_eq("t4_held_ready", 64'(ld_ready), 64'd0);
            check_eq("t4_held_count", 64'(lq_count), 64'd4);
        end
        drive_alu(1'b0, '0, '0);
        for (int k = 0; k < 5; k++) expect_wr(4'(8 + k), 32'h4000 + k);
        tick();
        check_eq("t4_ready_again", 64'(ld_ready), 64'd1);
        check_eq("t4_count_pop", 64'(lq_count), 64'd3);
        tick();
        drive_ld(1'b0, '0, '0);
        check_eq("t4_count_pushpop", 64'(lq_count), 64'd3);
        repeat (6) tick();
        check_eq("t4_drained", 64'(lq_count), 64'd0);
        check_eq("t4_sb_empty", 64'(exp_q.size()), 64'd0);

        // WAW: ALU write kills an older queued load to the same register
        drive_ld(1'b1, 4'd7, 32'h77);
        tick();
        drive_ld(1'b0, '0, '0);
        drive_alu(1'b1, 4'd7, 32'h55);
        check_eq("t5_pend7_set", 64'(pend_mask[7]), 64'd1);
        tick();
        drive_alu(1'b0, '0, '0);
        check_eq("t5_pend7_clr", 64'(pend_mask[7]), 64'd0);
        check_eq("t5_alu_dest", 64'(WB_dest), 64'd7);
        tick();
        check_eq("t5_kill_no_wr", 64'(WB_en), 64'd0);
        check_eq("t5_count0", 64'(lq_count), 64'd0);

        // Same-edge load and ALU write to one register
        drive_ld(1'b1, 4'd2, 32'hBEEF);
        drive_alu(1'b1, 4'd2, 32'h22);
        check_eq("t6_ready", 64'(ld_ready), 64'd1);
        tick();
        drive_ld(1'b0, '0, '0);
        drive_alu(1'b0, '0, '0);
        check_eq("t6_count1", 64'(lq_count), 64'd1);
        check_eq("t6_pend2", 64'(pend_mask[2]), 64'd0);
        tick();
        check_eq("t6_kill_no_wr", 64'(WB_en), 64'd0);
        check_eq("t6_count0", 64'(lq_count), 64'd0);

        // Two live loads to the same register both write, oldest first
        drive_ld(1'b1, 4'd4, 32'h41);
        expect_wr(4'd4, 32'h41);
        tick();
        drive_ld(1'b1, 4'd4, 32'h42);
        expect_wr(4'd4, 32'h42);
        tick();
        drive_ld(1'b0, '0, '0);
        repeat (4) tick();

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        check_eq("final_count", 64'(lq_count), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
